// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BIN_W      = 16;                 // binary input width
    localparam int N_DIGITS   = 4;                  // BCD digits presented to the display
    localparam int ITER_CNT   = 16;                 // one SHIFT cycle per input bit
    localparam int ACC_DIGITS = 5;                  // 65535 needs five BCD digits
    localparam int ACC_W      = 4 * ACC_DIGITS;     // BCD accumulator width
    localparam int CNT_W      = 5;                  // iteration counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit_val,
    output logic [3:0] digit_adj
);

    // Add 3 to digits >= 5; the largest legal input (9) yields 12, so 4 bits suffice.
    always_comb begin
        digit_adj = digit_val;
        if (digit_val >= 4'd5) begin
            digit_adj = digit_val + 4'd3;
        end else begin
            digit_adj = digit_val;
        end
    end

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (shift-and-add-3).
// One conversion takes 16 SHIFT cycles followed by a single DONE cycle.
// Optional build macro BCD_SATURATE_EN: values above 9999 display 9999
// instead of the low four decimal digits; ovf is raised either way.
module bin_to_bcd_seq
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit [N_DIGITS],
    output logic             ovf
);

`ifdef BCD_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    state_t           state_r;
    state_t           state_nx_s;
    logic [BIN_W-1:0] sr_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W-1:0] adj_s;
    logic [ACC_W-1:0] acc_shift_s;
    logic [BIN_W-1:0] sr_shift_s;
    logic             last_iter_s;
    logic             busy_nx_s;
    logic             done_nx_s;
    logic             ovf_nx_s;
    logic             sat_s;
    logic [3:0]       digit_nx_s [N_DIGITS];

    // One correction cell per accumulator digit, including the overflow digit.
    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_val (acc_r[4*g +: 4]),
            .digit_adj (adj_s[4*g +: 4])
        );
    end

    // Adjusted accumulator and shift register move left as one 36-bit word.
    assign acc_shift_s = {adj_s[ACC_W-2:0], sr_r[BIN_W-1]};
    assign sr_shift_s  = {sr_r[BIN_W-2:0], 1'b0};
    assign last_iter_s = (cnt_r == 5'(ITER_CNT - 1));

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so it is never queued.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_iter_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode: next values of the registered status flags and result digits.
    always_comb begin
        busy_nx_s = (state_nx_s == SHIFT);
        done_nx_s = (state_nx_s == DONE);
        ovf_nx_s  = (acc_shift_s[ACC_W-1 -: 4] != 4'd0);
        sat_s     = SATURATE & ovf_nx_s;
        for (int i = 0; i < N_DIGITS; i++) begin
            digit_nx_s[i] = sat_s ? 4'd9 : acc_shift_s[4*i +: 4];
        end
    end

    // Datapath: capture operand on start, then shift once per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r  <= 16'd0;
            acc_r <= 20'd0;
            cnt_r <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sr_r  <= bin;
                        acc_r <= 20'd0;
                        cnt_r <= 5'd0;
                    end
                end
                SHIFT: begin
                    sr_r  <= sr_shift_s;
                    acc_r <= acc_shift_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered outputs; the result is latched on the final shift so it is
    // valid in the DONE cycle and held until the next conversion completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                digit[i] <= 4'h0;
            end
        end else begin
            busy <= busy_nx_s;
            done <= done_nx_s;
            if (done_nx_s) begin
                ovf <= ovf_nx_s;
                for (int i = 0; i < N_DIGITS; i++) begin
                    digit[i] <= digit_nx_s[i];
                end
            end
        end
    end

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed steps with a scoreboard of
// expected {ovf, digit3..digit0} values derived by decimal division.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  digit [N_DIGITS];

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [16:0] exp_q [$];

    bin_to_bcd_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .digit (digit),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] model(input logic [15:0] v);
        int unsigned x;
        logic [15:0] d;
        logic        o;
        x = v;
        o = (x > 9999);
        d = {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
`ifdef BCD_SATURATE_EN
        if (o) d = 16'h9999;
`endif
        return {o, d};
    endfunction

    function automatic logic [15:0] digits_now();
        return {digit[3], digit[2], digit[1], digit[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a done pulse, counting busy cycles on the way.
    task automatic wait_done(output int lat, output int busy_n, output logic got);
        lat = 0; busy_n = 0; got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = k; got = 1'b1;
                break;
            end
        end
    endtask

    task automatic convert(input logic [15:0] v);
        int          lat, bn;
        logic        got;
        logic [16:0] e;
        @(posedge clk); #1;
        start = 1'b1; bin = v;
        exp_q.push_back(model(v));
        @(posedge clk); #1;
        start = 1'b0; bin = ~v;            // operand changes after capture
        wait_done(lat, bn, got);
        e = exp_q.pop_front();
        chk($sformatf("done_seen_%0d", v), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("latency_%0d", v), 32'(lat), 32'd17);
            chk($sformatf("busy_cycles_%0d", v), 32'(bn), 32'd16);
            chk($sformatf("digits_%0d", v), 32'(digits_now()), 32'(e[15:0]));
            chk($sformatf("ovf_%0d", v), 32'(ovf), 32'(e[16]));
            @(negedge clk);
            chk($sformatf("done_single_%0d", v), 32'(done), 32'd0);
            chk($sformatf("hold_digits_%0d", v), 32'(digits_now()), 32'(e[15:0]));
            chk($sformatf("hold_ovf_%0d", v), 32'(ovf), 32'(e[16]));
        end
    endtask

    initial begin
        int          lat, bn, dcount;
        logic        got;
        logic [16:0] e;
        int unsigned t1, t2;
        logic [15:0] dir [13];

        // Reset state
        reset = 1'b1; start = 1'b0; bin = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_digits", 32'(digits_now()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed values and boundaries
        dir = '{16'd1234, 16'd0, 16'd9999, 16'd65535, 16'd1, 16'd9, 16'd10,
                16'd99, 16'd100, 16'd999, 16'd1000, 16'd10000, 16'd40960};
        for (int i = 0; i < 13; i++) convert(dir[i]);

        // Random sweep sample
        for (int i = 0; i < 150; i++) convert(16'($urandom_range(0, 65535)));

        // Start held high: back-to-back conversions, operand changed mid-SHIFT
        @(posedge clk); #1;
        start = 1'b1; bin = 16'd42;
        exp_q.push_back(model(16'd42));
        exp_q.push_back(model(16'd42));
        wait_done(lat, bn, got);
        t1 = cyc;
        e = exp_q.pop_front();
        chk("held_done1", 32'(got), 32'd1);
        chk("held_digits1", 32'(digits_now()), 32'(e[15:0]));
        repeat (5) @(posedge clk);
        #1 bin = 16'd7;
        wait_done(lat, bn, got);
        t2 = cyc;
        start = 1'b0;
        e = exp_q.pop_front();
        chk("held_done2", 32'(got), 32'd1);
        chk("held_interval", 32'(t2 - t1), 32'd18);
        chk("held_digits2", 32'(digits_now()), 32'(e[15:0]));
        chk("held_ovf2", 32'(ovf), 32'(e[16]));
        repeat (3) @(negedge clk);
        chk("held_no_requeue", 32'(busy), 32'd0);

        // Reset in SHIFT cycle 8 aborts the conversion
        @(posedge clk); #1;
        start = 1'b1; bin = 16'd1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_digits", 32'(digits_now()), 32'd0);
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        // Reset overrides start in the same cycle
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; bin = 16'd555;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_over_start", 32'(busy), 32'd0);

        // First conversion after abort
        convert(16'd10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters: none; widths SHALL come from package constants BIN_W=16 and N_DIGITS=4.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  request conversion of bin; sampled only in IDLE.
REQ-005 bin  input  16  unsigned binary value to convert.
REQ-006 busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-007 done  output  1  single-cycle pulse marking new digits/ovf valid.
REQ-008 digit  output  4 x 4 (unpacked [4], index 0 = units)  BCD digits; drives the 4-nibble input of the seven-segment display driver directly.
REQ-009 ovf  output  1  last converted value exceeded 9999.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-011 IDLE: start=1 SHALL load bin into a 16-bit shift register, clear a 20-bit BCD accumulator (5 digits), clear a 5-bit iteration counter, and go to SHIFT.
REQ-012 SHIFT: each cycle SHALL add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left by 1 in the same cycle.
REQ-013 SHIFT SHALL last exactly 16 cycles (counter 0..15), then go to DONE.
REQ-014 DONE: digit[0..3] and ovf SHALL be registered from the accumulator, done=1 for this cycle only, then go to IDLE.
REQ-015 Latency: start sampled in cycle N -> done=1 in cycle N+17; next start accepted from cycle N+18.
REQ-016 start while busy or in DONE SHALL be ignored (not queued); bin changes after capture SHALL NOT affect the result.
REQ-017 ovf SHALL be 1 when the fifth BCD digit is nonzero (bin > 9999), else 0.
REQ-018 digit and ovf SHALL hold their last values between done pulses.
REQ-019 busy SHALL be 1 only in SHIFT; done SHALL be 1 only in DONE.
REQ-020 Digit adjust arithmetic SHALL be 4-bit; adjusted digit never exceeds 4'd12 before shift.

Reset
REQ-021 reset SHALL force IDLE, busy=0, done=0, ovf=0, all digit=4'h0, counter and registers cleared.
REQ-022 reset mid-SHIFT SHALL abort the conversion with no done pulse; reset overrides start in the same cycle.

Configuration
REQ-023 Macro BCD_SATURATE_EN: when defined, a value >9999 SHALL present digit = 9,9,9,9 with ovf=1.
REQ-024 Without BCD_SATURATE_EN, a value >9999 SHALL present the low 4 BCD digits (value mod 10000) with ovf=1.
REQ-025 Values <=9999 SHALL produce identical outputs with or without the macro.

Structure
REQ-026 Package bcd_pkg SHALL hold BIN_W, N_DIGITS, ITER_CNT=16 and the state enum typedef (IDLE, SHIFT, DONE).
REQ-027 One sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 if >=5) SHALL be instantiated per accumulator digit (5 instances).
REQ-028 No other sub-modules; the FSM, counter and shift path live in bin_to_bcd_seq.

Verification
REQ-029 bin=16'd1234, start pulse in IDLE -> 17 cycles later done=1, digit[3..0]=1,2,3,4, ovf=0; busy high exactly 16 cycles.
REQ-030 bin=16'd0 -> digits 0,0,0,0, ovf=0; bin=16'd9999 -> 9,9,9,9, ovf=0.
REQ-031 bin=16'd65535 -> ovf=1; digits 9,9,9,9 with BCD_SATURATE_EN, 5,5,3,5 without.
REQ-032 start held high continuously with bin=16'd42 -> done pulses every 18 cycles, digits 0,0,4,2; bin changed to 16'd7 mid-SHIFT -> result still 0,0,4,2.
REQ-033 reset asserted at SHIFT cycle 8 -> no done, all outputs 0 next cycle, IDLE; subsequent start with 16'd10000 -> ovf=1 after 17 cycles.
REQ-034 Exhaustive sweep 0..65535 against a reference model -> all digits/ovf match per active macro setting.
